tester_gtx_gen: RTL and testbench

//  Transmit-side pattern generator for the GTX link tester; feeds the GTX TX user interface (tx_data/tx_char) on usrclk.

---
 rtl/tester_gtx_gen.sv | 110 +++++++++++
 tb/tb_tester_gtx_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tester_gtx_gen.sv
// Transmit-side pattern generator for the GTX link tester: bursts of an
// incrementing 16-bit data stream separated by IDLE K-characters, with optional
// single-word error injection.
module tester_gtx_gen #(
  parameter logic [15:0] IDLE      = 16'h02bc,
  parameter logic [15:0] INIT_IDLE = 16'd64,
  parameter logic [15:0] BURST_LEN = 16'd1024,
  parameter logic [15:0] GAP_LEN   = 16'd4,
  parameter logic [15:0] START_VAL = 16'h0001
) (
  input  logic        usrclk,
  input  logic        usrrst,
  input  logic        enable,
  input  logic        err_inj,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_char,
  output logic        burst_done,
  output logic [15:0] inj_cnt
);

  localparam logic [1:0] CHAR_DATA = 2'b00;
  localparam logic [1:0] CHAR_IDLE = 2'b01;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_DATA = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] seq;
  logic [15:0] len_cnt;
  logic        inj_pend;

  // Each state emits one word per cycle; the registered outputs carry the word
  // chosen this cycle, so it appears on tx_data/tx_char one cycle later.
  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; a blocking '=' would let later lines see new values.
  always_ff @(posedge usrclk) begin
    if (usrrst) begin
      state      <= S_INIT;
      seq        <= START_VAL;
      len_cnt    <= '0;
      inj_pend   <= 1'b0;
      tx_data    <= IDLE;
      tx_char    <= CHAR_IDLE;
      burst_done <= 1'b0;
      inj_cnt    <= '0;
    end else begin
      tx_data    <= IDLE;
      tx_char    <= CHAR_IDLE;
      burst_done <= 1'b0;

      if (!enable) begin
        // Hold in init; seq and any pending injection survive the pause.
        state    <= S_INIT;
        len_cnt  <= '0;
        inj_pend <= inj_pend | err_inj;
      end else begin
        unique case (state)
          S_INIT: begin
            inj_pend <= inj_pend | err_inj;
            if (len_cnt == INIT_IDLE - 16'd1) begin
              len_cnt <= '0;
              state   <= S_DATA;
            end else begin
              len_cnt <= len_cnt + 16'd1;
            end
          end

          S_DATA: begin
            tx_char <= CHAR_DATA;
            tx_data <= inj_pend ? ~seq : seq;
            seq     <= seq + 16'd1;
            // A pending request is consumed here; a new pulse this cycle re-arms
            // it, so in both cases the next pending value is simply err_inj.
            inj_pend <= err_inj;
            if (inj_pend && (inj_cnt != 16'hFFFF)) begin
              inj_cnt <= inj_cnt + 16'd1;
            end
            if (len_cnt == BURST_LEN - 16'd1) begin
              burst_done <= 1'b1;
              len_cnt    <= '0;
              state      <= S_GAP;
            end else begin
              len_cnt <= len_cnt + 16'd1;
            end
          end

          S_GAP: begin
            inj_pend <= inj_pend | err_inj;
            if (len_cnt == GAP_LEN - 16'd1) begin
              len_cnt <= '0;
              state   <= S_DATA;
            end else begin
              len_cnt <= len_cnt + 16'd1;
            end
          end

          default: begin
            inj_pend <= inj_pend | err_inj;
            len_cnt  <= '0;
            state    <= S_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tester_gtx_gen.sv
// Bench for tester_gtx_gen: vector table on a short-parameter instance (wrap,
// injection corners), directed and random runs on a default instance vs a model.
module tb_tester_gtx_gen;

  localparam logic [15:0] IDLE = 16'h02bc;
  localparam int INIT = 64;
  localparam int BURST = 1024;
  localparam int GAP = 4;

  logic usrclk = 1'b0;
  always #5 usrclk = ~usrclk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- default-parameter instance ----------------
  logic        rst, en, inj;
  logic [15:0] tx_data, inj_cnt;
  logic [1:0]  tx_char;
  logic        burst_done;

  tester_gtx_gen dut (
    .usrclk(usrclk), .usrrst(rst), .enable(en), .err_inj(inj),
    .tx_data(tx_data), .tx_char(tx_char), .burst_done(burst_done), .inj_cnt(inj_cnt)
  );

  // ---------------- short-parameter instance for table vectors ----------------
  logic        rst2, en2, inj2;
  logic [15:0] tx_data2, inj_cnt2;
  logic [1:0]  tx_char2;
  logic        burst_done2;

  tester_gtx_gen #(
    .IDLE(16'h02bc), .INIT_IDLE(16'd2), .BURST_LEN(16'd8), .GAP_LEN(16'd2), .START_VAL(16'hFFFC)
  ) dut2 (
    .usrclk(usrclk), .usrrst(rst2), .enable(en2), .err_inj(inj2),
    .tx_data(tx_data2), .tx_char(tx_char2), .burst_done(burst_done2), .inj_cnt(inj_cnt2)
  );

  // ---------------- reference model ----------------
  // Position in the run (k) decides the word class by plain arithmetic:
  // first INIT words idle, then repeating periods of BURST data + GAP idle.
  int          m_k;
  logic [15:0] m_seq, m_cnt;
  logic        m_pend;
  logic [15:0] e_data;
  logic [1:0]  e_char;
  logic        e_done;

  task automatic model_edge(input logic r, input logic e, input logic i);
    int p;
    e_data = IDLE;
    e_char = 2'b01;
    e_done = 1'b0;
    if (r) begin
      m_k = 0; m_seq = 16'h0001; m_cnt = 0; m_pend = 1'b0;
    end else if (!e) begin
      m_k = 0;
      m_pend = m_pend | i;
    end else begin
      if (m_k < INIT) begin
        m_pend = m_pend | i;
      end else begin
        p = (m_k - INIT) % (BURST + GAP);
        if (p < BURST) begin
          e_char = 2'b00;
          if (m_pend) begin
            e_data = ~m_seq;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            m_pend = i;
          end else begin
            e_data = m_seq;
            m_pend = i;
          end
          e_done = (p == BURST - 1);
          m_seq = m_seq + 1;
        end else begin
          m_pend = m_pend | i;
        end
      end
      m_k++;
    end
  endtask

  // One clock on the default instance: drive, clock, advance model, compare.
  task automatic step(input logic r, input logic e, input logic i);
    rst = r; en = e; inj = i;
    @(posedge usrclk);
    model_edge(r, e, i);
    #1;
    check("tx_data", tx_data, e_data);
    check("tx_char", tx_char, e_char);
    check("burst_done", burst_done, e_done);
    check("inj_cnt", inj_cnt, m_cnt);
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, en, inj;
    logic [15:0] data;
    logic [1:0]  chr;
    logic        done;
    logic [15:0] icnt;
  } vec_t;

  function automatic vec_t mkv(logic r, logic e, logic i, logic [15:0] d,
                               logic [1:0] c, logic dn, logic [15:0] ic);
    vec_t v;
    v.rst = r; v.en = e; v.inj = i; v.data = d; v.chr = c; v.done = dn; v.icnt = ic;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    // INIT=2, BURST=8, GAP=2, START=FFFC
    tbl[0]  = mkv(1, 0, 0, IDLE,     2'b01, 0, 0);
    tbl[1]  = mkv(0, 1, 0, IDLE,     2'b01, 0, 0);
    tbl[2]  = mkv(0, 1, 0, IDLE,     2'b01, 0, 0);
    tbl[3]  = mkv(0, 1, 0, 16'hFFFC, 2'b00, 0, 0);
    tbl[4]  = mkv(0, 1, 1, 16'hFFFD, 2'b00, 0, 0);
    tbl[5]  = mkv(0, 1, 0, 16'h0001, 2'b00, 0, 1);  // ~FFFE
    tbl[6]  = mkv(0, 1, 0, 16'hFFFF, 2'b00, 0, 1);
    tbl[7]  = mkv(0, 1, 0, 16'h0000, 2'b00, 0, 1);
    tbl[8]  = mkv(0, 1, 0, 16'h0001, 2'b00, 0, 1);
    tbl[9]  = mkv(0, 1, 0, 16'h0002, 2'b00, 0, 1);
    tbl[10] = mkv(0, 1, 0, 16'h0003, 2'b00, 1, 1);
    tbl[11] = mkv(0, 1, 0, IDLE,     2'b01, 0, 1);
    tbl[12] = mkv(0, 1, 1, IDLE,     2'b01, 0, 1);
    tbl[13] = mkv(0, 1, 1, 16'hFFFB, 2'b00, 0, 2);  // ~0004, re-armed
    tbl[14] = mkv(0, 1, 0, 16'hFFFA, 2'b00, 0, 3);  // ~0005
    tbl[15] = mkv(0, 1, 0, 16'h0006, 2'b00, 0, 3);
    tbl[16] = mkv(0, 0, 0, IDLE,     2'b01, 0, 3);
    tbl[17] = mkv(0, 1, 0, IDLE,     2'b01, 0, 3);
    tbl[18] = mkv(0, 1, 0, IDLE,     2'b01, 0, 3);
    tbl[19] = mkv(0, 1, 0, 16'h0007, 2'b00, 0, 3);

    rst = 1'b1; en = 1'b0; inj = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; inj2 = 1'b0;
    m_k = 0; m_seq = 16'h0001; m_cnt = 0; m_pend = 1'b0;
    #1;

    for (int i = 0; i < 20; i++) begin
      rst2 = tbl[i].rst; en2 = tbl[i].en; inj2 = tbl[i].inj;
      @(posedge usrclk);
      #1;
      check($sformatf("tbl%0d.data", i), tx_data2, tbl[i].data);
      check($sformatf("tbl%0d.char", i), tx_char2, tbl[i].chr);
      check($sformatf("tbl%0d.done", i), burst_done2, tbl[i].done);
      check($sformatf("tbl%0d.icnt", i), inj_cnt2, tbl[i].icnt);
    end

    // Reset state, then the first burst and gap.
    step(1'b1, 1'b0, 1'b0);
    check("reset_data", tx_data, IDLE);
    check("reset_char", tx_char, 2'b01);
    check("reset_icnt", inj_cnt, 16'h0000);
    run(INIT);
    check("last_init_idle", tx_char, 2'b01);
    // Injection aimed at word 0010.
    run(14);
    check("word_000e", tx_data, 16'h000E);
    step(1'b0, 1'b1, 1'b1);
    check("word_000f", tx_data, 16'h000F);
    step(1'b0, 1'b1, 1'b0);
    check("corrupt_0010", tx_data, 16'hFFEF);
    check("inj_cnt_1", inj_cnt, 16'h0001);
    step(1'b0, 1'b1, 1'b0);
    check("after_corrupt_0011", tx_data, 16'h0011);
    // Disable after word 0123, re-enable.
    run(16'h0123 - 16'h0011);
    check("word_0123", tx_data, 16'h0123);
    step(1'b0, 1'b0, 1'b0);
    check("disable_idle", tx_char, 2'b01);
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 1'b0);
    run(INIT);
    check("reenable_idle", tx_data, IDLE);
    run(1);
    check("resume_0124", tx_data, 16'h0124);
    // Reset mid-burst.
    run(50);
    step(1'b1, 1'b1, 1'b0);
    check("midrst_char", tx_char, 2'b01);
    check("midrst_icnt", inj_cnt, 16'h0000);
    run(INIT + 1);
    check("first_after_rst", tx_data, 16'h0001);
    run(BURST - 1);
    check("last_of_burst", tx_data, 16'h0400);
    check("burst_done", burst_done, 1'b1);
    // Two injections in the gap give one corruption.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    run(GAP - 2);
    check("gap_end_idle", tx_char, 2'b01);
    run(1);
    check("gap_inj_0401", tx_data, 16'hFBFE);
    check("gap_inj_cnt", inj_cnt, 16'h0001);
    run(1);
    check("after_gap_inj_0402", tx_data, 16'h0402);

    // Random stimulus against the model.
    for (int j = 0; j < 4000; j++) begin
      step(($urandom_range(0, 799) == 0), ($urandom_range(0, 59) != 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
